// File: rtl/rv32_pc_pkg.sv
// rtl/rv32_pc_pkg.sv - shared types, step sizes and trap-vector helper for the PC unit
package rv32_pc_pkg;

   typedef enum logic [2:0] {
      TRAP,
      MRET,
      REDIRECT,
      RAS,
      SEQ,
      HOLD
   } pc_src_e;

   localparam int ILEN16_STEP = 2;
   localparam int ILEN32_STEP = 4;
   localparam int MAX_XLEN    = 64;

   // Callers zero-extend to MAX_XLEN and truncate the result back to their own width.
   function automatic logic [MAX_XLEN-1:0] vector_addr(input logic [MAX_XLEN-1:0] base,
                                                       input logic [4:0]          cause);
      return {base[MAX_XLEN-1:2], 2'b00} + {{(MAX_XLEN-7){1'b0}}, cause, 2'b00};
   endfunction

endpackage

// File: rtl/rv32_ras.sv
// rtl/rv32_ras.sv - circular return-address stack with saturating occupancy count
module rv32_ras
   import rv32_pc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [XLEN-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop_ok;
   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;

   assign empty   = (cnt_q == '0);
   assign top     = mem_q[ptr_q];
   assign pop_ok  = pop && !empty;
   assign ptr_inc = ptr_q + PTR_W'(1);

   // Push+pop replaces the top in place; a lone push past DEPTH overwrites the oldest slot.
   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_addr = ptr_q;
      if (push && pop_ok) begin
         wr_en   = 1'b1;
         wr_addr = ptr_q;
      end else if (push) begin
         wr_en   = 1'b1;
         wr_addr = ptr_inc;
         ptr_d   = ptr_inc;
         if (cnt_q != CNT_W'(DEPTH)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (pop_ok) begin
         ptr_d = ptr_q - PTR_W'(1);
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         if (wr_en) begin
            mem_q[wr_addr] <= push_data;
         end
      end
   end

endmodule

// File: rtl/rv32_pc_unit.sv
// rtl/rv32_pc_unit.sv - fetch PC generation with trap/mret/redirect/RAS/sequential source priority
module rv32_pc_unit
   import rv32_pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h1000_0000),
   parameter int              RAS_DEPTH    = 4,
   parameter int              SUPPORT_C    = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            is_compressed,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] pc_current,
   output logic [XLEN-1:0] pc_next,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic [4:0]      trap_cause,
   input  logic [XLEN-1:0] mtvec_base,
   input  logic            mtvec_vectored,
   input  logic            mret_valid,
   output logic [XLEN-1:0] mepc,
   input  logic            ras_push,
   input  logic            ras_pop,
   output logic            misaligned_fault
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic            started_q;
   logic            fault_q, fault_d;

   logic            compressed;
   logic            advance;
   logic            redirect_bad;
   logic [XLEN-1:0] trap_target;
   logic [XLEN-1:0] ras_top;
   logic            ras_empty;
   logic            ras_do_push;
   logic            ras_do_pop;
   pc_src_e         src;

   assign compressed   = (SUPPORT_C != 0) && is_compressed;
   assign pc_next      = pc_q + (compressed ? XLEN'(ILEN16_STEP) : XLEN'(ILEN32_STEP));
   assign fetch_valid  = started_q && !stall;
   assign advance      = fetch_valid && fetch_ready;
   assign redirect_bad = redirect_target[0] || ((SUPPORT_C == 0) && redirect_target[1]);
   assign trap_target  = mtvec_vectored
                         ? XLEN'(vector_addr(MAX_XLEN'(mtvec_base), trap_cause))
                         : {mtvec_base[XLEN-1:2], 2'b00};

   always_comb begin
      src = HOLD;
      if (trap_valid)                          src = TRAP;
      else if (mret_valid)                     src = MRET;
      else if (redirect_valid)                 src = REDIRECT;
      else if (advance && ras_pop && !ras_empty) src = RAS;
      else if (advance)                        src = SEQ;
   end

   // The stack only moves on plain advance cycles; any redirect-class source freezes it.
   assign ras_do_push = ((src == RAS) || (src == SEQ)) && ras_push;
   assign ras_do_pop  = (src == RAS);

   always_comb begin
      pc_d    = pc_q;
      mepc_d  = mepc_q;
      fault_d = 1'b0;
      case (src)
         TRAP: begin
            pc_d   = trap_target;
            mepc_d = pc_q;
         end
         MRET:     pc_d = mepc_q;
         REDIRECT: begin
            if (redirect_bad) fault_d = 1'b1;
            else              pc_d    = redirect_target;
         end
         RAS:      pc_d = ras_top;
         SEQ:      pc_d = pc_next;
         default:  pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q      <= RESET_VECTOR;
         mepc_q    <= '0;
         started_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         mepc_q    <= mepc_d;
         started_q <= 1'b1;
         fault_q   <= fault_d;
      end
   end

   rv32_ras #(
      .DEPTH (RAS_DEPTH),
      .XLEN  (XLEN)
   ) u_ras (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (ras_do_push),
      .pop       (ras_do_pop),
      .push_data (pc_next),
      .top       (ras_top),
      .empty     (ras_empty)
   );

   assign pc_current       = pc_q;
   assign mepc             = mepc_q;
   assign misaligned_fault = fault_q;

endmodule

// File: tb/tb_rv32_pc_unit.sv
// tb/tb_rv32_pc_unit.sv - directed scoreboard bench for rv32_pc_unit (C and non-C builds)
module tb_rv32_pc_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall = 1'b0;
   logic        is_compressed = 1'b0;
   logic        fetch_ready = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        trap_valid = 1'b0;
   logic [4:0]  trap_cause = '0;
   logic [31:0] mtvec_base = '0;
   logic        mtvec_vectored = 1'b0;
   logic        mret_valid = 1'b0;
   logic        ras_push = 1'b0;
   logic        ras_pop = 1'b0;
   logic        fetch_valid;
   logic [31:0] pc_current, pc_next, mepc;
   logic        misaligned_fault;

   logic        nc_is_compressed = 1'b0;
   logic        nc_redirect_valid = 1'b0;
   logic [31:0] nc_redirect_target = '0;
   logic        nc_fetch_valid;
   logic [31:0] nc_pc_current, nc_pc_next, nc_mepc;
   logic        nc_fault;

   always #5 clk = ~clk;

   rv32_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h1000_0000), .RAS_DEPTH(4), .SUPPORT_C(1)) dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .is_compressed(is_compressed),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .pc_current(pc_current),
      .pc_next(pc_next), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .mtvec_base(mtvec_base),
      .mtvec_vectored(mtvec_vectored), .mret_valid(mret_valid), .mepc(mepc),
      .ras_push(ras_push), .ras_pop(ras_pop), .misaligned_fault(misaligned_fault)
   );

   rv32_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h1000_0000), .RAS_DEPTH(4), .SUPPORT_C(0)) dut_nc (
      .clk(clk), .reset_n(reset_n), .stall(1'b0), .is_compressed(nc_is_compressed),
      .fetch_valid(nc_fetch_valid), .fetch_ready(1'b0), .pc_current(nc_pc_current),
      .pc_next(nc_pc_next), .redirect_valid(nc_redirect_valid), .redirect_target(nc_redirect_target),
      .trap_valid(1'b0), .trap_cause(5'd0), .mtvec_base(32'h0), .mtvec_vectored(1'b0),
      .mret_valid(1'b0), .mepc(nc_mepc), .ras_push(1'b0), .ras_pop(1'b0),
      .misaligned_fault(nc_fault)
   );

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         0:       return pc_current;
         1:       return {31'b0, fetch_valid};
         2:       return mepc;
         3:       return {31'b0, misaligned_fault};
         4:       return pc_next;
         5:       return nc_pc_current;
         6:       return {31'b0, nc_fault};
         7:       return nc_pc_next;
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic expect_v(input string tag, input int sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.sel);
         checks++;
         assert (o === e.exp)
         else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic settle();
      #1;
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      expect_v("rst_pc", 0, 32'h1000_0000);
      expect_v("rst_fetch_valid", 1, 32'd0);
      expect_v("rst_mepc", 2, 32'd0);
      expect_v("rst_fault", 3, 32'd0);
      expect_v("nc_rst_pc", 5, 32'h1000_0000);
      drain();

      reset_n = 1'b1;
      expect_v("first_cycle_fetch_valid", 1, 32'd0);
      settle();
      cyc();
      expect_v("seq_pc0", 0, 32'h1000_0000);
      expect_v("started_fetch_valid", 1, 32'd1);
      expect_v("pc_next_32", 4, 32'h1000_0004);
      drain();
      expect_v("seq_pc1", 0, 32'h1000_0004);
      cyc();
      is_compressed = 1'b1;
      expect_v("pc_next_16", 4, 32'h1000_0006);
      settle();
      expect_v("seq_pc2", 0, 32'h1000_0006);
      cyc();
      is_compressed = 1'b0;
      expect_v("seq_pc3", 0, 32'h1000_000A);
      cyc();

      stall = 1'b1;
      expect_v("stall_fetch_valid", 1, 32'd0);
      settle();
      expect_v("stall_hold1", 0, 32'h1000_000A);
      cyc();
      expect_v("stall_hold2", 0, 32'h1000_000A);
      cyc();
      redirect_valid  = 1'b1;
      redirect_target = 32'h200;
      expect_v("redirect_in_stall", 0, 32'h200);
      cyc();
      stall           = 1'b0;
      redirect_target = 32'h104;
      expect_v("redirect_104", 0, 32'h104);
      cyc();

      redirect_valid = 1'b0;
      trap_valid     = 1'b1;
      trap_cause     = 5'd3;
      mtvec_base     = 32'h8000_0001;
      mtvec_vectored = 1'b1;
      expect_v("trap_vec_pc", 0, 32'h8000_000C);
      expect_v("trap_vec_mepc", 2, 32'h104);
      cyc();
      trap_valid = 1'b0;
      mret_valid = 1'b1;
      expect_v("mret_pc", 0, 32'h104);
      cyc();
      mret_valid = 1'b0;
      expect_v("after_mret_seq", 0, 32'h108);
      cyc();
      trap_valid     = 1'b1;
      mret_valid     = 1'b1;
      mtvec_vectored = 1'b0;
      mtvec_base     = 32'h8000_0003;
      expect_v("trap_direct_beats_mret_pc", 0, 32'h8000_0000);
      expect_v("trap_direct_mepc", 2, 32'h108);
      cyc();
      trap_valid = 1'b0;
      expect_v("mret_back", 0, 32'h108);
      cyc();
      mret_valid = 1'b0;

      redirect_valid  = 1'b1;
      redirect_target = 32'h301;
      expect_v("misaligned_hold", 0, 32'h108);
      expect_v("misaligned_pulse", 3, 32'd1);
      cyc();
      redirect_valid = 1'b0;
      expect_v("misaligned_pulse_end", 3, 32'd0);
      expect_v("after_misaligned_seq", 0, 32'h10C);
      cyc();

      redirect_valid  = 1'b1;
      redirect_target = 32'h100;
      expect_v("ras_setup", 0, 32'h100);
      cyc();
      redirect_valid = 1'b0;
      ras_push       = 1'b1;
      expect_v("push_32", 0, 32'h104);
      cyc();
      ras_push        = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h200;
      expect_v("ras_jump_200", 0, 32'h200);
      cyc();
      redirect_valid = 1'b0;
      ras_push       = 1'b1;
      is_compressed  = 1'b1;
      expect_v("push_16", 0, 32'h202);
      cyc();
      ras_push      = 1'b0;
      is_compressed = 1'b0;
      ras_pop       = 1'b1;
      expect_v("pop1", 0, 32'h202);
      cyc();
      expect_v("pop2", 0, 32'h104);
      cyc();
      expect_v("pop_empty_seq", 0, 32'h108);
      cyc();
      ras_pop = 1'b0;

      redirect_valid  = 1'b1;
      redirect_target = 32'h1000;
      expect_v("depth_setup", 0, 32'h1000);
      cyc();
      redirect_valid = 1'b0;
      ras_push       = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         expect_v("depth_push", 0, 32'h1000 + 32'(4 * i));
         cyc();
      end
      ras_push = 1'b0;
      ras_pop  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_v("depth_pop_lifo", 0, 32'h1014 - 32'(4 * i));
         cyc();
      end
      expect_v("depth_pop5_seq", 0, 32'h100C);
      cyc();
      ras_pop  = 1'b0;
      ras_push = 1'b1;
      expect_v("pp_push_a", 0, 32'h1010);
      cyc();
      expect_v("pp_push_b", 0, 32'h1014);
      cyc();
      ras_pop       = 1'b1;
      is_compressed = 1'b1;
      expect_v("push_pop_old_top", 0, 32'h1014);
      cyc();
      ras_push      = 1'b0;
      is_compressed = 1'b0;
      expect_v("pop_replaced_top", 0, 32'h1016);
      cyc();
      expect_v("pop_bottom", 0, 32'h1010);
      cyc();
      expect_v("pop_empty_again", 0, 32'h1014);
      cyc();
      ras_pop = 1'b0;

      #2;
      reset_n = 1'b0;
      expect_v("async_reset_pc", 0, 32'h1000_0000);
      expect_v("async_reset_fetch_valid", 1, 32'd0);
      expect_v("async_reset_mepc", 2, 32'd0);
      settle();
      reset_n = 1'b1;
      cyc();

      nc_is_compressed = 1'b1;
      expect_v("nc_pc_next_ignores_c", 7, 32'h1000_0004);
      settle();
      nc_redirect_valid  = 1'b1;
      nc_redirect_target = 32'h302;
      expect_v("nc_misaligned_hold", 5, 32'h1000_0000);
      expect_v("nc_misaligned_pulse", 6, 32'd1);
      cyc();
      nc_redirect_target = 32'h304;
      expect_v("nc_redirect_ok", 5, 32'h304);
      expect_v("nc_fault_clear", 6, 32'd0);
      cyc();
      nc_redirect_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
